// File: rtl/operand_fetch.sv
// operand_fetch: decoded-instruction operand fetch stage in front of a
// 16x32 register file, with writeback arbitration and operand forwarding.
module operand_fetch #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rs1,
  input  logic [ADDR_WIDTH-1:0] in_rs2,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data,
  output logic                  rf_write,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic [ADDR_WIDTH-1:0] rf_read_addr_a,
  output logic [ADDR_WIDTH-1:0] rf_read_addr_b,
  input  logic [DATA_WIDTH-1:0] rf_read_data_a,
  input  logic [DATA_WIDTH-1:0] rf_read_data_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rs1_data,
  output logic [DATA_WIDTH-1:0] out_rs2_data,
  output logic [ADDR_WIDTH-1:0] out_rd,
  output logic [TAG_WIDTH-1:0]  out_tag
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE,
    OUT
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_WIDTH-1:0] rs1_q, rs1_d;
  logic [ADDR_WIDTH-1:0] rs2_q, rs2_d;
  logic [ADDR_WIDTH-1:0] rd_q, rd_d;
  logic [TAG_WIDTH-1:0]  tag_q, tag_d;

  logic [DATA_WIDTH-1:0] op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0] op_b_q, op_b_d;
  logic [ADDR_WIDTH-1:0] ord_q, ord_d;
  logic [TAG_WIDTH-1:0]  otag_q, otag_d;

  logic commit;
  logic rs1_nz, rs2_nz;
  logic fwd_a, fwd_b;

  // Writeback owns the register file port whenever it is live.
  assign commit        = wb_valid && (wb_addr != '0);
  assign rf_write      = commit;
  assign rf_write_addr = wb_addr;
  assign rf_write_data = wb_data;

  assign rs1_nz = (rs1_q != '0);
  assign rs2_nz = (rs2_q != '0);
  assign fwd_a  = commit && rs1_nz && (wb_addr == rs1_q);
  assign fwd_b  = commit && rs2_nz && (wb_addr == rs2_q);

  assign in_ready     = reset && (state_q == IDLE);
  assign out_valid    = (state_q == OUT);
  assign out_rs1_data = op_a_q;
  assign out_rs2_data = op_b_q;
  assign out_rd       = ord_q;
  assign out_tag      = otag_q;

  always_comb begin
    state_d        = state_q;
    rs1_d          = rs1_q;
    rs2_d          = rs2_q;
    rd_d           = rd_q;
    tag_d          = tag_q;
    op_a_d         = op_a_q;
    op_b_d         = op_b_q;
    ord_d          = ord_q;
    otag_d         = otag_q;
    rf_read_addr_a = '0;
    rf_read_addr_b = '0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          rs1_d   = in_rs1;
          rs2_d   = in_rs2;
          rd_d    = in_rd;
          tag_d   = in_tag;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        rf_read_addr_a = rs1_q;
        rf_read_addr_b = rs2_q;
        // The file only samples reads on cycles without a write.
        if (!commit) begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        op_a_d  = !rs1_nz ? '0 : (fwd_a ? wb_data : rf_read_data_a);
        op_b_d  = !rs2_nz ? '0 : (fwd_b ? wb_data : rf_read_data_b);
        ord_d   = rd_q;
        otag_d  = tag_q;
        state_d = OUT;
      end
      OUT: begin
        if (fwd_a) begin
          op_a_d = wb_data;
        end
        if (fwd_b) begin
          op_b_d = wb_data;
        end
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      tag_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      ord_q   <= '0;
      otag_q  <= '0;
    end else begin
      state_q <= state_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      tag_q   <= tag_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      ord_q   <= ord_d;
      otag_q  <= otag_d;
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: register file model, architectural-state
// reference, queue scoreboard with a negedge monitor.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_rs1, in_rs2, in_rd;
  logic [7:0]  in_tag;
  logic        wb_valid;
  logic [3:0]  wb_addr;
  logic [31:0] wb_data;
  logic        rf_write;
  logic [3:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic [3:0]  rf_read_addr_a, rf_read_addr_b;
  logic [31:0] rf_read_data_a, rf_read_data_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs1_data, out_rs2_data;
  logic [3:0]  out_rd;
  logic [7:0]  out_tag;

  operand_fetch dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_tag(in_tag),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_write(rf_write), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data),
    .rf_read_addr_a(rf_read_addr_a), .rf_read_addr_b(rf_read_addr_b),
    .rf_read_data_a(rf_read_data_a), .rf_read_data_b(rf_read_data_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_rd(out_rd), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  // Register file environment, driven by the DUT's own write port.
  logic [31:0] rf [16];
  initial begin
    for (int i = 0; i < 16; i++) rf[i] = '0;
    rf_read_data_a = '0;
    rf_read_data_b = '0;
  end
  always @(posedge clk) begin
    if (rf_write) begin
      if (rf_write_addr != 0) rf[rf_write_addr] <= rf_write_data;
    end else begin
      rf_read_data_a <= (rf_read_addr_a == 0) ? 32'h0 : rf[rf_read_addr_a];
      rf_read_data_b <= (rf_read_addr_b == 0) ? 32'h0 : rf[rf_read_addr_b];
    end
  end

  // Reference: architectural register values plus in-flight queue.
  typedef struct {
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
    logic [7:0] tag;
    int         acc;
    bit         seen;
  } ent_t;

  ent_t        q[$];
  logic [31:0] arch [16];
  bit          hist [8192];
  int          cyc = 0;
  bit          rdy_s = 0;
  int          npass = 0;
  int          ntot = 0;
  bit          rmode = 0;

  initial begin
    for (int i = 0; i < 16; i++) arch[i] = '0;
    for (int i = 0; i < 8192; i++) hist[i] = 0;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)",
                  name, act, exp, cyc);
  endtask

  function automatic int stall_cnt(input int acc, input bit now_c);
    int k = 0;
    int idx = acc + 1;
    while (idx < 8192 &&
           ((idx < cyc) ? hist[idx] : (idx == cyc && now_c))) begin
      k++;
      idx++;
    end
    return k;
  endfunction

  always @(posedge clk) begin
    if (wb_valid && wb_addr != 0) begin
      arch[wb_addr] = wb_data;
      if (cyc < 8192) hist[cyc] = 1;
    end
    if (reset && in_valid && rdy_s)
      q.push_back('{in_rs1, in_rs2, in_rd, in_tag, cyc, 1'b0});
    cyc++;
  end

  bit          now_c;
  int          k, e_out;
  logic [3:0]  ea, eb;
  logic [31:0] xa, xb;

  always @(negedge clk) begin
    rdy_s = in_ready;
    if (!reset) begin
      chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
      q.delete();
    end else begin
      now_c = wb_valid && wb_addr != 0;
      chk("rf_write", {31'b0, rf_write}, {31'b0, now_c});
      chk("rf_write_addr", {28'b0, rf_write_addr}, {28'b0, wb_addr});
      chk("rf_write_data", rf_write_data, wb_data);
      chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() == 0});
      ea = 0;
      eb = 0;
      e_out = 0;
      if (q.size() != 0 && !q[0].seen) begin
        k = stall_cnt(q[0].acc, now_c);
        e_out = q[0].acc + 3 + k;
        if (cyc >= q[0].acc + 1 && cyc <= q[0].acc + 1 + k) begin
          ea = q[0].rs1;
          eb = q[0].rs2;
        end
      end
      chk("rd_addr_a", {28'b0, rf_read_addr_a}, {28'b0, ea});
      chk("rd_addr_b", {28'b0, rf_read_addr_b}, {28'b0, eb});
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", 32'h1, 32'h0);
        end else begin
          if (!q[0].seen) begin
            chk("latency", cyc, e_out);
            q[0].seen = 1;
          end
          xa = (q[0].rs1 == 0) ? 32'h0 : arch[q[0].rs1];
          xb = (q[0].rs2 == 0) ? 32'h0 : arch[q[0].rs2];
          chk("op_a", out_rs1_data, xa);
          chk("op_b", out_rs2_data, xb);
          chk("out_rd", {28'b0, out_rd}, {28'b0, q[0].rd});
          chk("out_tag", {24'b0, out_tag}, {24'b0, q[0].tag});
          if (out_ready) void'(q.pop_front());
        end
      end else if (q.size() != 0 && !q[0].seen && cyc >= e_out) begin
        chk("late_valid", 32'h0, 32'h1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rmode) begin
      wb_valid  = ($urandom % 100) < 35;
      wb_addr   = 4'($urandom_range(0, 7));
      wb_data   = $urandom;
      out_ready = ($urandom % 100) < 60;
    end
  endtask

  task automatic wb(input logic v, input logic [3:0] a,
                    input logic [31:0] d);
    wb_valid = v;
    wb_addr  = a;
    wb_data  = d;
  endtask

  // Returns in the first cycle after acceptance (the ISSUE cycle).
  task automatic issue(input logic [3:0] r1, input logic [3:0] r2,
                       input logic [3:0] rd, input logic [7:0] tg);
    int n = 0;
    in_rs1   = r1;
    in_rs2   = r2;
    in_rd    = rd;
    in_tag   = tg;
    in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 32'h0, 32'h1);
        break;
      end
      tick();
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    if (q.size() != 0) chk("drain_timeout", 32'h0, 32'h1);
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    in_rs1 = '0;
    in_rs2 = '0;
    in_rd = '0;
    in_tag = '0;
    wb(1'b0, 4'h0, 32'h0);
    out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    wb(1'b1, 4'd3, 32'h11);
    tick();
    wb(1'b1, 4'd5, 32'h22);
    tick();
    wb(1'b0, 4'd0, 32'h0);

    out_ready = 1'b1;
    issue(4'd3, 4'd5, 4'd7, 8'hA5);
    drain();

    issue(4'd3, 4'd5, 4'd7, 8'hA5);
    wb(1'b1, 4'd9, 32'h99);
    tick();
    tick();
    wb(1'b0, 4'd0, 32'h0);
    drain();

    issue(4'd3, 4'd5, 4'd7, 8'h3C);
    tick();
    wb(1'b1, 4'd3, 32'hDEAD);
    tick();
    wb(1'b0, 4'd0, 32'h0);
    drain();

    out_ready = 1'b0;
    issue(4'd3, 4'd5, 4'd1, 8'h5A);
    tick();
    tick();
    wb(1'b1, 4'd5, 32'hBEEF);
    tick();
    wb(1'b0, 4'd0, 32'h0);
    tick();
    out_ready = 1'b1;
    drain();

    wb(1'b1, 4'd0, 32'hFFFF);
    issue(4'd0, 4'd0, 4'd2, 8'h0F);
    drain();
    wb(1'b0, 4'd0, 32'h0);
    tick();

    issue(4'd1, 4'd2, 4'd3, 8'h77);
    #2 reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    tick();

    rmode = 1'b1;
    repeat (150) begin
      issue(4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
            4'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end
    rmode = 1'b0;
    wb(1'b0, 4'd0, 32'h0);
    out_ready = 1'b1;
    drain();
    tick();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
